prog_mem_loader: RTL and testbench



---
 rtl/prog_mem_loader.sv | 98 +++++++++
 tb/tb_prog_mem_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// Loadable instruction RAM: valid/ready load port fills words, fetch port reads with 1-cycle latency.
// Loading is full-rate with no stalls; unwritten, out-of-range or mid-load fetches return DEFAULT_WORD.
module prog_mem_loader #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 256,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 28'h00000AA
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iLoadStart,
  input  logic [ADDR_WIDTH-1:0] iLoadBase,
  input  logic [DATA_WIDTH-1:0] iLoadData,
  input  logic                  iLoadValid,
  input  logic                  iLoadLast,
  output logic                  oLoadReady,
  output logic                  oLoadDone,
  output logic                  oLoadError,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oReady
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so the pointer can hold DEPTH itself and saturate there.
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t                state;
  logic [PW-1:0]         ptr;
  logic [DEPTH-1:0]      valid;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          ptr_in;
  logic          fetch_in;
  logic          wr_en;
  logic [PW-1:0] base_ext;
  logic [PW-1:0] fetch_ext;

  assign base_ext  = {1'b0, iLoadBase};
  assign fetch_ext = {1'b0, iAddress};
  assign ptr_in    = (ptr < DEPTH_P);
  assign fetch_in  = (fetch_ext < DEPTH_P);
  assign wr_en     = (state == LOAD) && iLoadValid && ptr_in;

  // RAM array carries no reset; the valid bits mask stale contents.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[ptr[IW-1:0]] <= iLoadData;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= EMPTY;
      ptr          <= '0;
      valid        <= '0;
      oInstruction <= DEFAULT_WORD;
      oLoadReady   <= 1'b0;
      oLoadDone    <= 1'b0;
      oLoadError   <= 1'b0;
      oReady       <= 1'b0;
    end else begin
      oLoadDone    <= 1'b0;
      oInstruction <= (state == RUN && fetch_in && valid[iAddress[IW-1:0]])
                      ? mem[iAddress[IW-1:0]] : DEFAULT_WORD;
      case (state)
        EMPTY, RUN: begin
          if (iLoadStart) begin
            state      <= LOAD;
            ptr        <= (base_ext < DEPTH_P) ? base_ext : DEPTH_P;
            oLoadError <= 1'b0;
            oLoadReady <= 1'b1;
            oReady     <= 1'b0;
          end
        end
        LOAD: begin
          if (iLoadValid) begin
            if (ptr_in) begin
              valid[ptr[IW-1:0]] <= 1'b1;
              ptr                <= ptr + PW'(1);
            end else begin
              oLoadError <= 1'b1;
            end
            if (iLoadLast) begin
              state      <= RUN;
              oLoadDone  <= 1'b1;
              oLoadReady <= 1'b0;
              oReady     <= 1'b1;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader (DEPTH = 8): vector table for load/fetch/overlay,
// hand sequences for gaps, overflow, async reset and mid-session reset.
module tb_prog_mem_loader;
  localparam int DW = 28;
  localparam int AW = 16;
  localparam int DEPTH = 8;
  localparam logic [DW-1:0] DEF = 28'h00000AA;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iLoadStart;
  logic [AW-1:0] iLoadBase;
  logic [DW-1:0] iLoadData;
  logic          iLoadValid;
  logic          iLoadLast;
  logic          oLoadReady;
  logic          oLoadDone;
  logic          oLoadError;
  logic [AW-1:0] iAddress;
  logic [DW-1:0] oInstruction;
  logic          oReady;

  int tests = 0;
  int fails = 0;

  prog_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .DEFAULT_WORD(DEF)) dut (
    .Clock(Clock), .Reset(Reset),
    .iLoadStart(iLoadStart), .iLoadBase(iLoadBase), .iLoadData(iLoadData),
    .iLoadValid(iLoadValid), .iLoadLast(iLoadLast),
    .oLoadReady(oLoadReady), .oLoadDone(oLoadDone), .oLoadError(oLoadError),
    .iAddress(iAddress), .oInstruction(oInstruction), .oReady(oReady)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic          st;
    logic [AW-1:0] base;
    logic          vld;
    logic          last;
    logic [DW-1:0] dat;
    logic [AW-1:0] addr;
    logic [DW-1:0] e_ins;
    logic          e_rdy;
    logic          e_lrdy;
    logic          e_done;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [AW-1:0] base, input logic vld,
                              input logic last, input logic [DW-1:0] dat, input logic [AW-1:0] addr,
                              input logic [DW-1:0] e_ins, input logic e_rdy, input logic e_lrdy,
                              input logic e_done, input logic e_err);
    vec_t v;
    v.st = st; v.base = base; v.vld = vld; v.last = last; v.dat = dat; v.addr = addr;
    v.e_ins = e_ins; v.e_rdy = e_rdy; v.e_lrdy = e_lrdy; v.e_done = e_done; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [DW-1:0] ins, input logic rdy,
                         input logic lrdy, input logic done, input logic err);
    chk({tag, ".ins"},  32'(oInstruction), 32'(ins));
    chk({tag, ".rdy"},  32'(oReady),       32'(rdy));
    chk({tag, ".lrdy"}, 32'(oLoadReady),   32'(lrdy));
    chk({tag, ".done"}, 32'(oLoadDone),    32'(done));
    chk({tag, ".err"},  32'(oLoadError),   32'(err));
  endtask

  task automatic drive(input logic st, input logic [AW-1:0] base, input logic vld,
                       input logic last, input logic [DW-1:0] dat);
    iLoadStart = st; iLoadBase = base; iLoadValid = vld; iLoadLast = last; iLoadData = dat;
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    iAddress = a;
    tick();
    chk(tag, 32'(oInstruction), 32'(exp));
  endtask

  initial begin
    // Cycle table: inputs before an edge, outputs expected just after it.
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       0, DEF,          0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 28'h0,       0, DEF,          0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 28'h0000FA0, 0, DEF,          0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 28'h1010008, 0, DEF,          0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 28'h1020004, 0, DEF,          0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 28'h2030102, 0, DEF,          1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       0, 28'h0000FA0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       1, 28'h1010008,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       2, 28'h1020004,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       3, 28'h2030102,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       4, DEF,          1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       8, DEF,          1, 0, 0, 0));
    // Overlay at base 2; data beside the start pulse and a start inside LOAD are both ignored.
    vecs.push_back(mk(1, 2, 1, 0, 28'h5555555, 0, 28'h0000FA0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 1, 28'h0,       0, DEF,          0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 28'h3000000, 1, DEF,          1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       2, 28'h3000000,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       0, 28'h0000FA0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       1, 28'h1010008,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       3, 28'h2030102,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0,       5, DEF,          1, 0, 0, 0));

    Reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    iAddress = '0;
    #3;
    chk_all("por", DEF, 0, 0, 0, 0);
    #9 Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].base, vecs[i].vld, vecs[i].last, vecs[i].dat);
      iAddress = vecs[i].addr;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_ins, vecs[i].e_rdy, vecs[i].e_lrdy,
              vecs[i].e_done, vecs[i].e_err);
    end

    // Gaps: last held high while valid is low must not end the session.
    iAddress = '0;
    drive(1, 4, 0, 0, 0); tick(); chk("gap.start_lrdy", 32'(oLoadReady), 32'd1);
    drive(0, 0, 1, 0, 28'h0A0A0A1); tick();
    for (int w = 1; w < 3; w++) begin
      drive(0, 0, 0, 1, 0); tick(); chk("gap.idle_done", 32'(oLoadDone), 32'd0);
      tick(); chk("gap.idle_lrdy", 32'(oLoadReady), 32'd1);
      drive(0, 0, 1, (w == 2), (w == 1) ? 28'h0B0B0B2 : 28'h0C0C0C3); tick();
    end
    chk("gap.done", 32'(oLoadDone), 32'd1);
    chk("gap.rdy", 32'(oReady), 32'd1);
    drive(0, 0, 0, 0, 0);
    fetch("gap.f4", 4, 28'h0A0A0A1);
    chk("gap.done_drop", 32'(oLoadDone), 32'd0);
    fetch("gap.f5", 5, 28'h0B0B0B2);
    fetch("gap.f6", 6, 28'h0C0C0C3);
    fetch("gap.f7", 7, DEF);
    fetch("gap.f3", 3, 28'h2030102);

    // Overflow: base 6, words 3 and 4 fall beyond DEPTH.
    drive(1, 6, 0, 0, 0); tick(); chk("ovf.err0", 32'(oLoadError), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, (k == 3), 28'(32'h1111111 * (k + 1))); tick();
      chk($sformatf("ovf.err%0d", k), 32'(oLoadError), 32'(k >= 2));
      chk($sformatf("ovf.done%0d", k), 32'(oLoadDone), 32'(k == 3));
    end
    drive(0, 0, 0, 0, 0);
    fetch("ovf.f6", 6, 28'h1111111);
    fetch("ovf.f7", 7, 28'h2222222);
    fetch("ovf.f0", 0, 28'h0000FA0);
    chk("ovf.err_run", 32'(oLoadError), 32'd1);
    drive(1, 0, 0, 0, 0); tick(); chk("ovf.err_clr", 32'(oLoadError), 32'd0);
    drive(0, 0, 1, 1, 28'h7777777); tick(); chk("ovf.reload_done", 32'(oLoadDone), 32'd1);
    drive(0, 0, 0, 0, 0);
    fetch("ovf.reload_f0", 0, 28'h7777777);

    // Reset after 2 of 4 words of a session that has already overflowed.
    drive(1, 7, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 28'h6666666); tick(); chk("mid.err_a", 32'(oLoadError), 32'd0);
    drive(0, 0, 1, 0, 28'h6666667); tick(); chk("mid.err_b", 32'(oLoadError), 32'd1);
    drive(0, 0, 0, 0, 0);
    #2 Reset = 1'b1;
    #1 chk_all("mid.rst", DEF, 0, 0, 0, 0);
    #3 Reset = 1'b0;
    drive(1, 5, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 28'h5A5A5A5); tick();
    drive(0, 0, 0, 0, 0);
    fetch("mid.f0", 0, DEF);
    fetch("mid.f1", 1, DEF);
    fetch("mid.f7", 7, DEF);
    fetch("mid.f5", 5, 28'h5A5A5A5);

    // Async reset while RUN is driving a real word.
    #2 Reset = 1'b1;
    #1 chk_all("arst", DEF, 0, 0, 0, 0);
    #3 Reset = 1'b0;
    fetch("arst.empty_f5", 5, DEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
